video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have these parameters:
- H_ACTIVE, 1920, active pixels per line.
- H_FP, 88, horizontal front porch in pixels.
- H_SYNC, 44, hsync width in pixels.
- H_BP, 148, horizontal back porch in pixels.
- V_ACTIVE, 1080, active lines per frame.
- V_FP, 4, vertical front porch in lines.
- V_SYNC, 5, vsync width in lines.
- V_BP, 36, vertical back porch in lines.
- HS_POL, 1, hsync active level.
- VS_POL, 1, vsync active level.

REQ-002 The block SHALL have these ports:
- pclk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  timing advance enable.
- i_data  in  24  pixel from source (RGB888), valid the cycle after data_req.
- data_req  out  1  pixel request, one cycle ahead of o_de.
- o_hs  out  1  horizontal sync.
- o_vs  out  1  vertical sync.
- o_de  out  1  data enable.
- o_data  out  24  pixel aligned with o_de.
- o_x  out  12  active column.
- o_y  out  12  active line.
- o_sof  out  1  start-of-frame pulse.

Function
REQ-003 Internal position SHALL be h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; region order per axis: active, front porch, sync, back porch.
REQ-004 On each pclk edge with en=1, h SHALL increment; at h=H_TOTAL-1, h wraps to 0 and v increments; at (H_TOTAL-1, V_TOTAL-1), position wraps to (0,0).
REQ-005 On an edge with en=0, position SHALL hold.
REQ-006 All outputs except data_req SHALL be registered and SHALL describe the position reached at that edge (latency 1 from the counter update).
REQ-007 o_de SHALL be 1 iff the edge advanced (en=1) and the new position has h<H_ACTIVE and v<V_ACTIVE; it SHALL be 0 after any en=0 edge.
REQ-008 o_hs SHALL equal HS_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL; o_hs SHALL hold its value on en=0 edges.
REQ-009 o_vs SHALL equal VS_POL iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL; o_vs transitions SHALL therefore coincide with h=0; o_vs SHALL hold its value on en=0 edges.
REQ-010 o_x SHALL be h when o_de=1, else 0.
REQ-011 o_y SHALL be v when v<V_ACTIVE and the edge advanced, else 0.
REQ-012 o_sof SHALL be a one-cycle pulse on the edge that advances to (0,0); it is 0 on en=0 edges.
REQ-013 data_req SHALL be combinational: en AND (next position is active), so data_req in cycle t implies o_de=1 in cycle t+1.
REQ-014 i_data SHALL be captured on every edge where data_req=1 and presented on o_data in the same cycle as the matching o_de.
REQ-015 o_data SHALL be 24'h000000 whenever o_de=0.
REQ-016 Counter arithmetic SHALL use 12-bit widths; H_TOTAL and V_TOTAL SHALL be at most 4096 (parameter check at elaboration).

Reset
REQ-017 While rst=1 at an edge, position SHALL load (H_TOTAL-1, V_TOTAL-1), so the first enabled edge after reset produces o_sof.
REQ-018 While rst=1 at an edge, outputs SHALL be: o_de=0, o_sof=0, o_x=0, o_y=0, o_data=0, o_hs=~HS_POL, o_vs=~VS_POL.
REQ-019 While rst=1, data_req SHALL be 0.
REQ-020 rst SHALL override en.
REQ-021 Reset asserted mid-frame SHALL abandon the frame with no partial-line continuation.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset release with en=1, default params -> first edge o_sof=1, o_de=1, o_x=0, o_y=0; o_de high 1920 cycles per active line; 1080 such lines; frame period 2200*1125=2,475,000 cycles, o_sof exactly once per frame.
- Sync placement, default params -> o_hs=1 for 44 cycles starting at h=2008; o_vs=1 for 5*2200 cycles starting at (h=0, v=1084); the first o_vs edge coincides with an h=0 cycle.
- Data alignment: i_data returns a counter incremented on each data_req -> o_data equals o_x-derived value on every o_de cycle; o_data=0 in blanking.
- en deasserted 3 cycles at h=100 of line 5 -> o_de=0 and data_req=0 for those 3 cycles; position resumes at h=101 with no pixel lost or duplicated; o_hs and o_vs held.
- rst asserted 1 cycle at v=500 with en=1 -> outputs reach reset values (REQ-018) next edge; the following enabled edge produces o_sof=1 and (0,0).
- Reduced params H=16/2/3/2, V=8/1/2/1 -> H_TOTAL=23, V_TOTAL=12, frame period 276 cycles; wrap at (22,11)->(0,0) produces o_sof.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: walks an (h, v) position over the full frame
// (active, front porch, sync, back porch on each axis) and produces
// registered sync, data-enable, coordinates and pixel data, plus a
// combinational pixel request issued one cycle ahead of o_de.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] i_data,
  output logic        data_req,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [23:0] o_data,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_sof
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are 12 bits wide, so a frame larger than 4096 on either axis
  // cannot be represented.
  if (H_TOTAL > 4096) begin : g_h_total_chk
    $error("video_timing_gen: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 4096) begin : g_v_total_chk
    $error("video_timing_gen: V_TOTAL exceeds 4096");
  end

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // Region bounds carry one extra bit so an end bound equal to 4096 still fits.
  localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] r_h;
  logic [11:0] r_v;

  logic [11:0] w_h_nxt;
  logic [11:0] w_v_nxt;
  logic        w_h_act;
  logic        w_v_act;
  logic        w_act_nxt;
  logic        w_hs_nxt;
  logic        w_vs_nxt;
  logic        w_sof_nxt;

  // Position the counters move to on the next enabled edge, and its decode.
  always_comb begin
    w_h_nxt = r_h + 12'd1;
    w_v_nxt = r_v;
    if (r_h == H_LAST) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 12'd1;
    end
    w_h_act   = ({1'b0, w_h_nxt} < H_ACT);
    w_v_act   = ({1'b0, w_v_nxt} < V_ACT);
    w_act_nxt = w_h_act && w_v_act;
    w_hs_nxt  = (({1'b0, w_h_nxt} >= HS_BEG) && ({1'b0, w_h_nxt} < HS_END)) ? HS_POL : ~HS_POL;
    w_vs_nxt  = (({1'b0, w_v_nxt} >= VS_BEG) && ({1'b0, w_v_nxt} < VS_END)) ? VS_POL : ~VS_POL;
    w_sof_nxt = (w_h_nxt == '0) && (w_v_nxt == '0);
  end

  // The source sees the request in the cycle before the edge that raises o_de,
  // so the pixel it presents is captured on that same edge.
  assign data_req = en && !rst && w_act_nxt;

  // Advance the position and register all outputs for the position reached.
  // Reset parks at the last pixel so the first enabled edge starts a frame.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_h    <= H_LAST;
      r_v    <= V_LAST;
      o_de   <= 1'b0;
      o_sof  <= 1'b0;
      o_x    <= '0;
      o_y    <= '0;
      o_data <= '0;
      o_hs   <= ~HS_POL;
      o_vs   <= ~VS_POL;
    end else if (en) begin
      r_h    <= w_h_nxt;
      r_v    <= w_v_nxt;
      o_de   <= w_act_nxt;
      o_sof  <= w_sof_nxt;
      o_x    <= w_act_nxt ? w_h_nxt : '0;
      o_y    <= w_v_act ? w_v_nxt : '0;
      o_data <= w_act_nxt ? i_data : '0;
      o_hs   <= w_hs_nxt;
      o_vs   <= w_vs_nxt;
    end else begin
      // Stalled edge: syncs keep their level, per-pixel outputs go quiet.
      o_de   <= 1'b0;
      o_sof  <= 1'b0;
      o_x    <= '0;
      o_y    <= '0;
      o_data <= '0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_chk  = 0;
  int n_pass = 0;

  // default-parameter instance
  logic        d_rst = 1'b1, d_en = 1'b0;
  logic        d_req, d_hs, d_vs, d_de, d_sof;
  logic [23:0] d_idata, d_data;
  logic [11:0] d_x, d_y;
  logic [23:0] d_cnt;

  // reduced-parameter instance: H 16/2/3/2 (23), V 8/1/2/1 (12)
  logic        r_rst = 1'b1, r_en = 1'b0;
  logic        r_req, r_hs, r_vs, r_de, r_sof;
  logic [23:0] r_idata, r_data;
  logic [11:0] r_x, r_y;
  logic [23:0] r_cnt;

  video_timing_gen u_dut_def (
    .pclk(pclk), .rst(d_rst), .en(d_en), .i_data(d_idata), .data_req(d_req),
    .o_hs(d_hs), .o_vs(d_vs), .o_de(d_de), .o_data(d_data), .o_x(d_x), .o_y(d_y), .o_sof(d_sof)
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut_red (
    .pclk(pclk), .rst(r_rst), .en(r_en), .i_data(r_idata), .data_req(r_req),
    .o_hs(r_hs), .o_vs(r_vs), .o_de(r_de), .o_data(r_data), .o_x(r_x), .o_y(r_y), .o_sof(r_sof)
  );

  // Pixel source: returns a running count, bumped on every requested pixel.
  always @(posedge pclk) begin
    if (d_rst) d_cnt <= '0; else if (d_req) d_cnt <= d_cnt + 24'd1;
    if (r_rst) r_cnt <= '0; else if (r_req) r_cnt <= r_cnt + 24'd1;
  end
  assign d_idata = d_cnt;
  assign r_idata = r_cnt;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    d_rst = 1'b1; d_en = 1'b1; r_rst = 1'b1; r_en = 1'b1;
    repeat (3) tick();
    n_chk++; if (d_de   !== 1'b0)  $display("FAIL rst_de: got %0d want 0", d_de);     else n_pass++;
    n_chk++; if (d_sof  !== 1'b0)  $display("FAIL rst_sof: got %0d want 0", d_sof);   else n_pass++;
    n_chk++; if (d_x    !== 12'd0) $display("FAIL rst_x: got %0d want 0", d_x);       else n_pass++;
    n_chk++; if (d_y    !== 12'd0) $display("FAIL rst_y: got %0d want 0", d_y);       else n_pass++;
    n_chk++; if (d_data !== 24'd0) $display("FAIL rst_data: got %0h want 0", d_data); else n_pass++;
    n_chk++; if (d_hs   !== 1'b0)  $display("FAIL rst_hs: got %0d want 0", d_hs);     else n_pass++;
    n_chk++; if (d_vs   !== 1'b0)  $display("FAIL rst_vs: got %0d want 0", d_vs);     else n_pass++;
    n_chk++; if (d_req  !== 1'b0)  $display("FAIL rst_req: got %0d want 0", d_req);   else n_pass++;
    n_chk++; if (r_req  !== 1'b0)  $display("FAIL rst_req_red: got %0d want 0", r_req); else n_pass++;
  endtask

  task automatic test_first_line();
    int de_n = 0, sof_n = 0, hs_n = 0, hs_first = -1;
    int x_err = 0, dat_err = 0, vs_err = 0, y_err = 0, de_err = 0;
    d_rst = 1'b0;
    #1;
    n_chk++; if (d_req !== 1'b1) $display("FAIL first_req: got %0d want 1", d_req); else n_pass++;
    for (int c = 0; c < 2200; c++) begin
      logic e_de;
      tick();
      e_de = (c < 1920);
      if (c == 0) begin
        n_chk++; if (d_sof !== 1'b1)  $display("FAIL first_sof: got %0d want 1", d_sof); else n_pass++;
        n_chk++; if (d_de  !== 1'b1)  $display("FAIL first_de: got %0d want 1", d_de);   else n_pass++;
        n_chk++; if (d_x   !== 12'd0) $display("FAIL first_x: got %0d want 0", d_x);     else n_pass++;
        n_chk++; if (d_y   !== 12'd0) $display("FAIL first_y: got %0d want 0", d_y);     else n_pass++;
      end
      if (d_de === 1'b1) de_n++;
      if (d_sof === 1'b1) sof_n++;
      if (d_hs === 1'b1) begin
        if (hs_first < 0) hs_first = c;
        hs_n++;
      end
      if (d_de !== e_de) de_err++;
      if (d_x !== (e_de ? 12'(c) : 12'd0)) x_err++;
      if (d_data !== (e_de ? 24'(c) : 24'd0)) dat_err++;
      if (d_vs !== 1'b0) vs_err++;
      if (d_y !== 12'd0) y_err++;
    end
    n_chk++; if (de_n != 1920)   $display("FAIL line_de_count: got %0d want 1920", de_n);   else n_pass++;
    n_chk++; if (de_err != 0)    $display("FAIL line_de_place: got %0d bad want 0", de_err); else n_pass++;
    n_chk++; if (hs_first != 2008) $display("FAIL hs_start: got %0d want 2008", hs_first);  else n_pass++;
    n_chk++; if (hs_n != 44)     $display("FAIL hs_width: got %0d want 44", hs_n);          else n_pass++;
    n_chk++; if (sof_n != 1)     $display("FAIL line_sof_count: got %0d want 1", sof_n);    else n_pass++;
    n_chk++; if (x_err != 0)     $display("FAIL line_x: got %0d bad want 0", x_err);        else n_pass++;
    n_chk++; if (dat_err != 0)   $display("FAIL line_data: got %0d bad want 0", dat_err);   else n_pass++;
    n_chk++; if (vs_err != 0)    $display("FAIL line_vs: got %0d bad want 0", vs_err);      else n_pass++;
    n_chk++; if (y_err != 0)     $display("FAIL line_y: got %0d bad want 0", y_err);        else n_pass++;
  endtask

  task automatic test_en_pause();
    // from (2199,0) to (100,5)
    repeat (8901) tick();
    n_chk++; if (d_x !== 12'd100)     $display("FAIL pre_pause_x: got %0d want 100", d_x);      else n_pass++;
    n_chk++; if (d_y !== 12'd5)       $display("FAIL pre_pause_y: got %0d want 5", d_y);        else n_pass++;
    n_chk++; if (d_data !== 24'd9700) $display("FAIL pre_pause_data: got %0d want 9700", d_data); else n_pass++;
    d_en = 1'b0;
    #1;
    n_chk++; if (d_req !== 1'b0) $display("FAIL pause_req_now: got %0d want 0", d_req); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (d_de !== 1'b0)    $display("FAIL pause_de[%0d]: got %0d want 0", i, d_de);     else n_pass++;
      n_chk++; if (d_req !== 1'b0)   $display("FAIL pause_req[%0d]: got %0d want 0", i, d_req);   else n_pass++;
      n_chk++; if (d_data !== 24'd0) $display("FAIL pause_data[%0d]: got %0d want 0", i, d_data); else n_pass++;
      n_chk++; if ((d_hs !== 1'b0) || (d_vs !== 1'b0)) $display("FAIL pause_sync[%0d]: got hs=%0d vs=%0d want 0/0", i, d_hs, d_vs); else n_pass++;
    end
    d_en = 1'b1;
    #1;
    n_chk++; if (d_req !== 1'b1) $display("FAIL resume_req: got %0d want 1", d_req); else n_pass++;
    tick();
    n_chk++; if (d_x !== 12'd101)     $display("FAIL resume_x: got %0d want 101", d_x);        else n_pass++;
    n_chk++; if (d_y !== 12'd5)       $display("FAIL resume_y: got %0d want 5", d_y);          else n_pass++;
    n_chk++; if (d_de !== 1'b1)       $display("FAIL resume_de: got %0d want 1", d_de);        else n_pass++;
    n_chk++; if (d_data !== 24'd9701) $display("FAIL resume_data: got %0d want 9701", d_data); else n_pass++;
    // stall inside hsync: the sync level must be held
    repeat (1909) tick();
    n_chk++; if (d_hs !== 1'b1) $display("FAIL hs_at_2010: got %0d want 1", d_hs); else n_pass++;
    d_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++; if (d_hs !== 1'b1) $display("FAIL hs_hold[%0d]: got %0d want 1", i, d_hs); else n_pass++;
    end
    d_en = 1'b1;
    tick();
    n_chk++; if (d_hs !== 1'b1) $display("FAIL hs_at_2011: got %0d want 1", d_hs); else n_pass++;
  endtask

  task automatic test_mid_reset();
    // from (2011,5) to (50,6)
    repeat (239) tick();
    n_chk++; if ((d_x !== 12'd50) || (d_y !== 12'd6)) $display("FAIL pre_rst_pos: got %0d,%0d want 50,6", d_x, d_y); else n_pass++;
    n_chk++; if (d_data !== 24'd11570) $display("FAIL pre_rst_data: got %0d want 11570", d_data); else n_pass++;
    n_chk++; if (d_req !== 1'b1) $display("FAIL pre_rst_req: got %0d want 1", d_req); else n_pass++;
    d_rst = 1'b1;
    #1;
    n_chk++; if (d_req !== 1'b0) $display("FAIL in_rst_req: got %0d want 0", d_req); else n_pass++;
    tick();
    n_chk++; if (d_de !== 1'b0)    $display("FAIL mid_rst_de: got %0d want 0", d_de);     else n_pass++;
    n_chk++; if ((d_x !== 12'd0) || (d_y !== 12'd0)) $display("FAIL mid_rst_xy: got %0d,%0d want 0,0", d_x, d_y); else n_pass++;
    n_chk++; if (d_data !== 24'd0) $display("FAIL mid_rst_data: got %0d want 0", d_data); else n_pass++;
    n_chk++; if ((d_hs !== 1'b0) || (d_vs !== 1'b0) || (d_sof !== 1'b0)) $display("FAIL mid_rst_sync: got hs=%0d vs=%0d sof=%0d want 0/0/0", d_hs, d_vs, d_sof); else n_pass++;
    d_rst = 1'b0;
    #1;
    n_chk++; if (d_req !== 1'b1) $display("FAIL post_rst_req: got %0d want 1", d_req); else n_pass++;
    tick();
    n_chk++; if (d_sof !== 1'b1) $display("FAIL post_rst_sof: got %0d want 1", d_sof); else n_pass++;
    n_chk++; if (d_de !== 1'b1)  $display("FAIL post_rst_de: got %0d want 1", d_de);   else n_pass++;
    n_chk++; if ((d_x !== 12'd0) || (d_y !== 12'd0)) $display("FAIL post_rst_xy: got %0d,%0d want 0,0", d_x, d_y); else n_pass++;
    tick();
    n_chk++; if ((d_x !== 12'd1) || (d_data !== 24'd1) || (d_sof !== 1'b0)) $display("FAIL post_rst_next: got x=%0d data=%0d sof=%0d want 1/1/0", d_x, d_data, d_sof); else n_pass++;
  endtask

  task automatic test_reduced_frame();
    int sof_n = 0, de_n = 0, hs_n = 0, vs_n = 0, vs_first = -1;
    int err_de = 0, err_hs = 0, err_vs = 0, err_sof = 0, err_x = 0, err_y = 0, err_dat = 0;
    r_rst = 1'b0;
    for (int c = 0; c < 552; c++) begin
      int h, v, f;
      logic e_de, e_hs, e_vs, e_sof;
      tick();
      h = c % 23; v = (c / 23) % 12; f = c / 276;
      e_de  = (h < 16) && (v < 8);
      e_hs  = (h >= 18) && (h < 21);
      e_vs  = (v >= 9) && (v < 11);
      e_sof = (h == 0) && (v == 0);
      if (r_de !== e_de) err_de++;
      if (r_hs !== e_hs) err_hs++;
      if (r_vs !== e_vs) err_vs++;
      if (r_sof !== e_sof) err_sof++;
      if (r_x !== (e_de ? 12'(h) : 12'd0)) err_x++;
      if (r_y !== ((v < 8) ? 12'(v) : 12'd0)) err_y++;
      if (r_data !== (e_de ? 24'(f * 128 + v * 16 + h) : 24'd0)) err_dat++;
      if (r_sof === 1'b1) sof_n++;
      if (r_de === 1'b1) de_n++;
      if (r_hs === 1'b1) hs_n++;
      if (r_vs === 1'b1) begin
        if (vs_first < 0) vs_first = c;
        vs_n++;
      end
      if (c == 276) begin
        n_chk++; if (r_sof !== 1'b1) $display("FAIL red_wrap_sof: got %0d want 1", r_sof); else n_pass++;
      end
    end
    n_chk++; if (sof_n != 2)    $display("FAIL red_sof_count: got %0d want 2", sof_n);   else n_pass++;
    n_chk++; if (de_n != 256)   $display("FAIL red_de_count: got %0d want 256", de_n);   else n_pass++;
    n_chk++; if (hs_n != 72)    $display("FAIL red_hs_count: got %0d want 72", hs_n);    else n_pass++;
    n_chk++; if (vs_first != 207) $display("FAIL red_vs_start: got %0d want 207", vs_first); else n_pass++;
    n_chk++; if (vs_n != 92)    $display("FAIL red_vs_count: got %0d want 92", vs_n);    else n_pass++;
    n_chk++; if (err_de != 0)   $display("FAIL red_de: got %0d bad want 0", err_de);     else n_pass++;
    n_chk++; if (err_hs != 0)   $display("FAIL red_hs: got %0d bad want 0", err_hs);     else n_pass++;
    n_chk++; if (err_vs != 0)   $display("FAIL red_vs: got %0d bad want 0", err_vs);     else n_pass++;
    n_chk++; if (err_sof != 0)  $display("FAIL red_sof: got %0d bad want 0", err_sof);   else n_pass++;
    n_chk++; if (err_x != 0)    $display("FAIL red_x: got %0d bad want 0", err_x);       else n_pass++;
    n_chk++; if (err_y != 0)    $display("FAIL red_y: got %0d bad want 0", err_y);       else n_pass++;
    n_chk++; if (err_dat != 0)  $display("FAIL red_data: got %0d bad want 0", err_dat);  else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_en_pause();
    test_mid_reset();
    test_reduced_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
